// File: rtl/line_pi_pkg.sv
// Shared types and defaults for the line-follower PI controller.
// Contents: FSM state enum, default timing/gain constants, internal widths,
// and the saturating helpers used by the datapath.
package line_pi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    CONV_R,
    SHORT,
    CONV_L,
    INTG,
    ICOMP,
    PCOMP,
    MRT_R,
    MRT_L
  } state_t;

  localparam int unsigned DEF_N_PAIRS    = 3;
  localparam logic [17:0] DEF_CHNL_MAP   = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};
  localparam int unsigned DEF_SETTLE_CYC = 4096;
  localparam int unsigned DEF_SHORT_CYC  = 32;
  localparam int unsigned DEF_PWM_PERIOD = 240;
  localparam int unsigned DEF_PWM_DUTY   = 140;
  localparam logic [13:0] DEF_KP         = 14'h3680;
  localparam logic [11:0] DEF_KI         = 12'h500;
  localparam int unsigned DEF_INT_DEC    = 4;
  localparam logic [11:0] DEF_FWD_MAX    = 12'h700;

  // Accumulator must hold +/- 4095 * (2^N_PAIRS - 1) for up to 4 pairs.
  localparam int ACC_W = 18;
  localparam int TMR_W = 16;

  function automatic logic signed [11:0] sat12(input logic signed [31:0] x);
    if (x > 32'sd2047) begin
      return 12'sh7FF;
    end else if (x < -32'sd2048) begin
      return 12'sh800;
    end else begin
      return x[11:0];
    end
  endfunction

  // Motor commands keep only the upper 11 bits of the saturated 12-bit value.
  function automatic logic [10:0] cmd11(input logic signed [31:0] x);
    return 11'(sat12(x) >>> 1);
  endfunction

endpackage

// File: rtl/line_pi_cntrl_if.sv
// Bundle of the controller's A2D and motor-side signals.
// master: controller side (drives conversion request, emitters, motor commands).
// slave : environment side (A2D model / motor drivers / run enable).
//   go, cnv_cmplt, A2D_res            -> into controller
//   strt_cnv, chnnl, IR_en, LEDs,
//   lft, rht, loop_done               <- from controller
interface line_pi_cntrl_if #(
  parameter int unsigned N_PAIRS = 3
);
  logic               go;
  logic               cnv_cmplt;
  logic [11:0]        A2D_res;
  logic               strt_cnv;
  logic [2:0]         chnnl;
  logic [N_PAIRS-1:0] IR_en;
  logic [7:0]         LEDs;
  logic [10:0]        lft;
  logic [10:0]        rht;
  logic               loop_done;

  modport master (
    input  go, cnv_cmplt, A2D_res,
    output strt_cnv, chnnl, IR_en, LEDs, lft, rht, loop_done
  );

  modport slave (
    output go, cnv_cmplt, A2D_res,
    input  strt_cnv, chnnl, IR_en, LEDs, lft, rht, loop_done
  );
endinterface

// File: rtl/line_pi_cntrl_ir_pwm.sv
// Emitter PWM generator shared by all IR pairs.
// Ports: clk, rst (async active-high), clr_i holds the counter at 0,
//        pwm_o is high for counts 0..PWM_DUTY-1 of each PWM_PERIOD.
module ir_pwm #(
  parameter int unsigned PWM_PERIOD = 240,
  parameter int unsigned PWM_DUTY   = 140
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic pwm_o
);
  localparam int CW = $clog2(PWM_PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CW'(PWM_PERIOD - 1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwm_o = (cnt_q < CW'(PWM_DUTY));
endmodule

// File: rtl/line_pi_cntrl.sv
// Line-follower controller: scans N_PAIRS IR sensor pairs through the shared
// A2D, forms a weighted steering error, runs a decimated PI loop and writes
// signed left/right motor commands.
// Ports: clk, rst (async active-high), bus (line_pi_cntrl_if.master):
//   go/cnv_cmplt/A2D_res in; strt_cnv/chnnl/IR_en/LEDs/lft/rht/loop_done out.
//
// state  | meaning
// IDLE   | stopped, waiting for go
// SETTLE | emitter on, long settle before right-sensor conversion
// CONV_R | waiting for right-sensor result, add weighted reading
// SHORT  | short settle before left-sensor conversion
// CONV_L | waiting for left-sensor result, subtract weighted reading
// INTG   | decimated integrator update, forward speed ramp
// ICOMP  | two cycles: integral term through multiplier
// PCOMP  | two cycles: proportional term through multiplier
// MRT_R  | write right motor command
// MRT_L  | write left motor command, restart scan
module line_pi_cntrl
  import line_pi_pkg::*;
#(
  parameter int unsigned          N_PAIRS    = DEF_N_PAIRS,
  parameter logic [6*N_PAIRS-1:0] CHNL_MAP   = DEF_CHNL_MAP,
  parameter int unsigned          SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned          SHORT_CYC  = DEF_SHORT_CYC,
  parameter int unsigned          PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int unsigned          PWM_DUTY   = DEF_PWM_DUTY,
  parameter logic [13:0]          KP         = DEF_KP,
  parameter logic [11:0]          KI         = DEF_KI,
  parameter int unsigned          INT_DEC    = DEF_INT_DEC,
  parameter logic [11:0]          FWD_MAX    = DEF_FWD_MAX
) (
  input logic             clk,
  input logic             rst,
  line_pi_cntrl_if.master bus
);
  localparam int         DEC_W  = $clog2(INT_DEC + 1);
  localparam logic [1:0] P_LAST = 2'(N_PAIRS - 1);

  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [1:0]               p_q, p_d;
  logic signed [ACC_W-1:0]  accum_q, accum_d;
  logic signed [ACC_W-1:0]  res_sh;
  logic signed [11:0]       error_q, error_d;
  logic signed [11:0]       intgrl_q, intgrl_d;
  logic [DEC_W-1:0]         dec_q, dec_d;
  logic signed [11:0]       fwd_q, fwd_d;
  logic signed [11:0]       icomp_q, icomp_d;
  logic signed [11:0]       pcomp_q, pcomp_d;
  logic [10:0]              lft_q, lft_d;
  logic [10:0]              rht_q, rht_d;
  logic                     done_q, done_d;

  logic signed [11:0]       op_a;
  logic signed [14:0]       op_b;
  logic signed [26:0]       prod_q;

  logic                     pwm;
  logic                     strt_cnv;
  logic [2:0]               chnnl;
  logic [N_PAIRS-1:0]       ir_en;

  ir_pwm #(
    .PWM_PERIOD (PWM_PERIOD),
    .PWM_DUTY   (PWM_DUTY)
  ) u_ir_pwm (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .pwm_o (pwm)
  );

  // Shared multiplier: operands selected by state, product registered; the
  // owning state shifts/saturates the registered product on its second cycle.
  always_comb begin
    op_a = intgrl_q;
    op_b = signed'({3'b000, KI});
    if (state_q == PCOMP) begin
      op_a = error_q;
      op_b = signed'({1'b0, KP});
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    p_d      = p_q;
    accum_d  = accum_q;
    error_d  = error_q;
    intgrl_d = intgrl_q;
    dec_d    = dec_q;
    fwd_d    = fwd_q;
    icomp_d  = icomp_q;
    pcomp_d  = pcomp_q;
    lft_d    = lft_q;
    rht_d    = rht_q;
    done_d   = 1'b0;
    strt_cnv = 1'b0;
    res_sh   = ACC_W'(bus.A2D_res) << p_q;

    if (!bus.go) begin
      // go has priority over everything, including a coincident cnv_cmplt.
      state_d = IDLE;
      lft_d   = '0;
      rht_d   = '0;
      fwd_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          accum_d = '0;
          p_d     = '0;
          timer_d = '0;
        end
        SETTLE: begin
          if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
            strt_cnv = 1'b1;
            state_d  = CONV_R;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        CONV_R: begin
          if (bus.cnv_cmplt) begin
            accum_d = accum_q + res_sh;
            timer_d = '0;
            state_d = SHORT;
          end
        end
        SHORT: begin
          if (timer_q == TMR_W'(SHORT_CYC - 1)) begin
            strt_cnv = 1'b1;
            state_d  = CONV_L;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        CONV_L: begin
          if (bus.cnv_cmplt) begin
            accum_d = accum_q - res_sh;
            if (p_q == P_LAST) begin
              error_d = sat12(32'(accum_d));
              state_d = INTG;
            end else begin
              p_d     = p_q + 1'b1;
              timer_d = '0;
              state_d = SETTLE;
            end
          end
        end
        INTG: begin
          if (dec_q == DEC_W'(INT_DEC - 1)) begin
            dec_d    = '0;
            intgrl_d = sat12(32'(intgrl_q) + 32'(error_q >>> 4));
          end else begin
            dec_d = dec_q + 1'b1;
          end
          if (fwd_q != FWD_MAX) begin
            fwd_d = fwd_q + 1'b1;
          end
          timer_d = '0;
          state_d = ICOMP;
        end
        ICOMP: begin
          if (timer_q[0]) begin
            icomp_d = sat12(32'(prod_q >>> 11));
            timer_d = '0;
            state_d = PCOMP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        PCOMP: begin
          if (timer_q[0]) begin
            pcomp_d = sat12(32'(prod_q >>> 13));
            timer_d = '0;
            state_d = MRT_R;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        MRT_R: begin
          rht_d   = cmd11(32'(fwd_q) - 32'(pcomp_q) - 32'(icomp_q));
          state_d = MRT_L;
        end
        MRT_L: begin
          lft_d   = cmd11(32'(fwd_q) + 32'(pcomp_q) + 32'(icomp_q));
          done_d  = 1'b1;
          p_d     = '0;
          accum_d = '0;
          timer_d = '0;
          state_d = SETTLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // chnnl follows the scan position so it is already valid in the strt_cnv
  // cycle and holds until the matching cnv_cmplt.
  always_comb begin
    chnnl = '0;
    ir_en = '0;
    unique case (state_q)
      SETTLE, CONV_R: chnnl = CHNL_MAP[6*p_q +: 3];
      SHORT, CONV_L:  chnnl = CHNL_MAP[6*p_q + 3 +: 3];
      default:        chnnl = '0;
    endcase
    if (bus.go && (state_q inside {SETTLE, CONV_R, SHORT, CONV_L})) begin
      ir_en[p_q] = pwm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      p_q      <= '0;
      accum_q  <= '0;
      error_q  <= '0;
      intgrl_q <= '0;
      dec_q    <= '0;
      fwd_q    <= '0;
      icomp_q  <= '0;
      pcomp_q  <= '0;
      lft_q    <= '0;
      rht_q    <= '0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      p_q      <= p_d;
      accum_q  <= accum_d;
      error_q  <= error_d;
      intgrl_q <= intgrl_d;
      dec_q    <= dec_d;
      fwd_q    <= fwd_d;
      icomp_q  <= icomp_d;
      pcomp_q  <= pcomp_d;
      lft_q    <= lft_d;
      rht_q    <= rht_d;
      done_q   <= done_d;
      prod_q   <= op_a * op_b;
    end
  end

  assign bus.strt_cnv  = strt_cnv;
  assign bus.chnnl     = chnnl;
  assign bus.IR_en     = ir_en;
  assign bus.LEDs      = error_q[11:4];
  assign bus.lft       = lft_q;
  assign bus.rht       = rht_q;
  assign bus.loop_done = done_q;
endmodule
